// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, bridge defaults and transmit sequencer states
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_BUSY_TIMEOUT = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with level count and same-cycle push/pop
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] din,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level
);
    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot, so a push at full is still accepted
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_tx_fifo_bridge.sv
// uart_rx_tx_fifo_bridge: queues received bytes and hands them to the transmitter one at a time when it is idle
module uart_rx_tx_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_done,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   tx_busy,
    output logic                   tx_en,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic [AW:0]            fifo_level,
    output logic                   overflow,
    input  logic                   clear_ovf
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [UART_DATA_W-1:0] head;
    logic full, empty, pop;
    assign pop = state == ISSUE;
    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(rx_done),
        .pop(pop),
        .din(rx_data),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
    // head is latched on entry to ISSUE so tx_data is valid alongside tx_en; the pointer advances during ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tx_en <= 1'b0;
            tx_data <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= (rx_done && full && !pop) ? 1'b1 : clear_ovf ? 1'b0 : overflow;
            tx_en <= 1'b0;
            case (state)
                IDLE:
                    if (!empty && !tx_busy) begin
                        state <= ISSUE;
                        tx_en <= 1'b1;
                        tx_data <= head;
                    end
                ISSUE: state <= WAIT_BUSY;
                WAIT_BUSY:
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                        cnt <= '0;
                    end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        state <= IDLE;
                        cnt <= '0;
                    end else cnt <= cnt + 1'b1;
                WAIT_DONE: if (!tx_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_tx_fifo_bridge.sv
// tb_uart_rx_tx_fifo_bridge: directed vector table plus sequences for burst, overflow, push+pop at full, timeout and reset
module tb_uart_rx_tx_fifo_bridge;
    logic clk = 0, rst = 1, rx_done = 0, tx_busy = 0, clear_ovf = 0;
    logic [7:0] rx_data = 0, tx_data;
    logic tx_en, overflow;
    logic [4:0] fifo_level;
    int checks = 0, failures = 0, cyc = 0, lvl_max = 0, bcnt = 0, busy_len = 0;
    bit model_on = 0, pend = 0;
    logic [7:0] log_d[$];
    int log_c[$];
    int falls[$];

    typedef struct {
        bit rst, rx_done, busy, clr;
        logic [7:0] rx_data;
        bit e_en, e_ovf;
        logic [7:0] e_data;
        int e_lvl;
    } vec_t;
    vec_t vt[12];

    uart_rx_tx_fifo_bridge dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_en(tx_en), .tx_data(tx_data), .fifo_level(fifo_level), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock; the transmitter model raises busy one cycle after tx_en and holds it busy_len cycles
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (model_on) begin
            if (pend) begin
                tx_busy = 1;
                bcnt = busy_len;
                pend = 0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    tx_busy = 0;
                    falls.push_back(cyc);
                end
            end
        end
        if (tx_en) begin
            log_d.push_back(tx_data);
            log_c.push_back(cyc);
            if (model_on) pend = 1;
        end
        if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    endtask

    task automatic do_reset();
        model_on = 0;
        pend = 0;
        bcnt = 0;
        tx_busy = 0;
        rx_done = 0;
        clear_ovf = 0;
        rst = 1;
        tick();
        rst = 0;
        log_d.delete();
        log_c.delete();
        falls.delete();
        lvl_max = 0;
    endtask

    task automatic send(logic [7:0] b);
        rx_done = 1;
        rx_data = b;
        tick();
        rx_done = 0;
    endtask

    initial begin
        // rst rxd busy clr data | en ovf data lvl
        vt[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        vt[1]  = '{0, 1, 0, 0, 8'hA5, 0, 0, 8'h00, 1};
        vt[2]  = '{0, 0, 0, 0, 8'h00, 1, 0, 8'hA5, 1};
        vt[3]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 0};
        vt[4]  = '{0, 0, 1, 0, 8'h00, 0, 0, 8'hA5, 0};
        vt[5]  = '{0, 1, 1, 0, 8'h3C, 0, 0, 8'hA5, 1};
        vt[6]  = '{0, 0, 1, 0, 8'h00, 0, 0, 8'hA5, 1};
        vt[7]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 1};
        vt[8]  = '{0, 0, 0, 0, 8'h00, 1, 0, 8'h3C, 1};
        vt[9]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'h3C, 0};
        vt[10] = '{0, 0, 0, 1, 8'h00, 0, 0, 8'h3C, 0};
        vt[11] = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0};
        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst;
            rx_done = vt[i].rx_done;
            rx_data = vt[i].rx_data;
            tx_busy = vt[i].busy;
            clear_ovf = vt[i].clr;
            tick();
            chk($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
        end

        // burst of five bytes, transmitter busy 20 cycles each
        do_reset();
        model_on = 1;
        busy_len = 20;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i));
            tick();
            tick();
        end
        for (int g = 0; g < 400 && falls.size() < 5; g++) tick();
        for (int g = 0; g < 5; g++) tick();
        chk("burst_count", log_d.size(), 5);
        if (log_d.size() == 5 && falls.size() >= 4) begin
            for (int i = 0; i < 5; i++) chk($sformatf("burst_data%0d", i), 32'(log_d[i]), 32'(i + 1));
            for (int i = 1; i < 5; i++) chk($sformatf("burst_gap%0d", i), log_c[i] - falls[i-1], 2);
        end
        chk("burst_level_peak", lvl_max, 4);

        // fill past full while the transmitter is held busy
        do_reset();
        tx_busy = 1;
        for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
        tick();
        chk("full_level", 32'(fifo_level), 16);
        chk("full_overflow", 32'(overflow), 1);
        clear_ovf = 1;
        tick();
        clear_ovf = 0;
        chk("clear_ovf", 32'(overflow), 0);

        // release the transmitter and push exactly in the ISSUE cycle
        log_d.delete();
        log_c.delete();
        tx_busy = 0;
        tick();
        chk("issue_tx_en", 32'(tx_en), 1);
        send(8'h99);
        chk("pushpop_level", 32'(fifo_level), 16);
        chk("pushpop_overflow", 32'(overflow), 0);

        // transmitter never answers: every handshake times out and the queue still drains
        for (int g = 0; g < 400 && log_d.size() < 17; g++) tick();
        for (int g = 0; g < 10; g++) tick();
        chk("drain_count", log_d.size(), 17);
        if (log_d.size() == 17) begin
            for (int i = 0; i < 16; i++) chk($sformatf("drain_data%0d", i), 32'(log_d[i]), 32'(8'h10 + i));
            chk("drain_data16", 32'(log_d[16]), 32'h99);
            for (int i = 1; i < 17; i++) chk($sformatf("timeout_gap%0d", i), log_c[i] - log_c[i-1], 6);
        end
        chk("drain_level", 32'(fifo_level), 0);

        // reset while waiting for the transmitter to finish
        do_reset();
        model_on = 1;
        busy_len = 10;
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        for (int g = 0; g < 50 && !tx_busy; g++) tick();
        chk("rst_busy_seen", 32'(tx_busy), 1);
        tick();
        tick();
        chk("rst_pre_level", 32'(fifo_level), 2);
        model_on = 0;
        rst = 1;
        tick();
        rst = 0;
        tx_busy = 0;
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        log_d.delete();
        for (int g = 0; g < 10; g++) tick();
        chk("rst_quiet", log_d.size(), 0);
        send(8'hC7);
        chk("rst_new_wait", 32'(tx_en), 0);
        tick();
        chk("rst_new_en", 32'(tx_en), 1);
        chk("rst_new_data", 32'(tx_data), 32'hC7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
